// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the mimic pipeline hazard controller.
// Holds the FSM state enum, parameter defaults and the stall/flush control bundle.
package pipeline_ctrl_pkg;

    localparam int unsigned RedirectCyclesDef = 2;
    localparam int unsigned DmemTimeoutDef    = 16;
    localparam int unsigned CntWDef           = 16;

    typedef enum logic [1:0] {
        StRun,
        StDmemWait,
        StRedirect
    } state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_if;
        logic stall_sub_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_if;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_sub_mem;
    } ctrl_t;

    function automatic ctrl_t ctrl_flush_all();
        ctrl_t c;
        c               = '0;
        c.flush_if      = 1'b1;
        c.flush_id      = 1'b1;
        c.flush_ex      = 1'b1;
        c.flush_mem     = 1'b1;
        c.flush_sub_mem = 1'b1;
        return c;
    endfunction

    // Data-memory wait: freeze everything, but drain the sub-MEM slot with a bubble.
    function automatic ctrl_t ctrl_dmem_stall();
        ctrl_t c;
        c               = '0;
        c.stall_pc      = 1'b1;
        c.stall_if      = 1'b1;
        c.stall_sub_if  = 1'b1;
        c.stall_id      = 1'b1;
        c.stall_ex      = 1'b1;
        c.stall_mem     = 1'b1;
        c.flush_sub_mem = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Event and control bundle between the pipeline and its hazard controller.
// The pipeline side drives events (master); the controller drives controls (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             load_use_hz;
    logic             imem_busy;
    logic             branch_taken;
    logic             dmem_busy;
    logic             trap_mem;

    logic             stall_pc;
    logic             stall_if;
    logic             stall_sub_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_mem;
    logic             flush_sub_mem;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output load_use_hz, imem_busy, branch_taken, dmem_busy, trap_mem,
        input  stall_pc, stall_if, stall_sub_if, stall_id, stall_ex, stall_mem,
        input  flush_if, flush_id, flush_ex, flush_mem, flush_sub_mem,
        input  dmem_timeout, stall_cycles
    );

    modport slave (
        input  load_use_hz, imem_busy, branch_taken, dmem_busy, trap_mem,
        output stall_pc, stall_if, stall_sub_if, stall_id, stall_ex, stall_mem,
        output flush_if, flush_id, flush_ex, flush_mem, flush_sub_mem,
        output dmem_timeout, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: fixed-priority decode of pipeline events into
// Mealy stall/flush controls, with multi-cycle redirect and data-memory wait handling.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_CYCLES = RedirectCyclesDef,
    parameter int unsigned DMEM_TIMEOUT    = DmemTimeoutDef,
    parameter int unsigned CNT_W           = CntWDef
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [3:0] RedirInit   = 4'(REDIRECT_CYCLES - 1);
    localparam logic [7:0] TimeoutLast = 8'(DMEM_TIMEOUT - 1);
    // A redirect of one cycle is fully served by the cycle that starts it.
    localparam state_e     RedirState  = (RedirInit != 4'd0) ? StRedirect : StRun;

    state_e     state_q, state_d;
    logic [3:0] redir_q, redir_d;
    logic [7:0] wait_q, wait_d;
    ctrl_t      ctrl;
    logic       timeout;
    logic [CNT_W-1:0] stall_cycles;

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        redir_d = redir_q;
        wait_d  = wait_q;
        timeout = bus.dmem_busy && (wait_q == TimeoutLast);

        // A nonzero redir_q outside REDIRECT means a redirect was suspended by the wait.
        if (state_q == StDmemWait && !bus.dmem_busy) begin
            wait_d  = '0;
            state_d = (redir_q != 4'd0) ? StRedirect : StRun;
        end else if (state_q == StRedirect && redir_q == 4'd0) begin
            state_d = StRun;
        end

        if (bus.trap_mem || timeout) begin
            ctrl    = ctrl_flush_all();
            state_d = RedirState;
            redir_d = RedirInit;
            wait_d  = '0;
        end else if (bus.dmem_busy) begin
            ctrl    = ctrl_dmem_stall();
            state_d = StDmemWait;
            wait_d  = wait_q + 8'd1;
        end else if (bus.branch_taken) begin
            ctrl.flush_if = 1'b1;
            ctrl.flush_id = 1'b1;
            state_d       = RedirState;
            redir_d       = RedirInit;
        end else if (state_q == StRedirect && redir_q != 4'd0) begin
            ctrl.flush_if = 1'b1;
            redir_d       = redir_q - 4'd1;
            state_d       = (redir_q == 4'd1) ? StRun : StRedirect;
        end else if (bus.imem_busy) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if     = 1'b1;
            ctrl.stall_sub_if = 1'b1;
            ctrl.flush_id     = 1'b1;
        end else if (bus.load_use_hz) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if     = 1'b1;
            ctrl.stall_sub_if = 1'b1;
            ctrl.stall_id     = 1'b1;
            ctrl.flush_ex     = 1'b1;
        end

        if (!rst) begin
            ctrl    = '0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            redir_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .inc_i   (ctrl.stall_pc),
        .count_o (stall_cycles)
    );

    assign bus.stall_pc      = ctrl.stall_pc;
    assign bus.stall_if      = ctrl.stall_if;
    assign bus.stall_sub_if  = ctrl.stall_sub_if;
    assign bus.stall_id      = ctrl.stall_id;
    assign bus.stall_ex      = ctrl.stall_ex;
    assign bus.stall_mem     = ctrl.stall_mem;
    assign bus.flush_if      = ctrl.flush_if;
    assign bus.flush_id      = ctrl.flush_id;
    assign bus.flush_ex      = ctrl.flush_ex;
    assign bus.flush_mem     = ctrl.flush_mem;
    assign bus.flush_sub_mem = ctrl.flush_sub_mem;
    assign bus.dmem_timeout  = timeout;
    assign bus.stall_cycles  = stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues hand-derived expected
// controls per cycle, the monitor pops and compares them on the falling edge.
module tb_pipeline_hazard_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam logic [4:0] EvNone = 5'b00000;
    localparam logic [4:0] EvLu   = 5'b10000;
    localparam logic [4:0] EvIm   = 5'b01000;
    localparam logic [4:0] EvBr   = 5'b00100;
    localparam logic [4:0] EvDb   = 5'b00010;
    localparam logic [4:0] EvTr   = 5'b00001;

    typedef struct {
        ctrl_t       c;
        logic        to;
        logic [15:0] sc;
        int          tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tag     = 0;
    logic [15:0] exp_sc = '0;
    ctrl_t c0, lu, im, br, rd, st, fl;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(
        .REDIRECT_CYCLES (2),
        .DMEM_TIMEOUT    (16),
        .CNT_W           (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input int n, input logic r, input logic [4:0] ev, input ctrl_t c,
                         input logic to);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst              = r;
            bus.load_use_hz  = ev[4];
            bus.imem_busy    = ev[3];
            bus.branch_taken = ev[2];
            bus.dmem_busy    = ev[1];
            bus.trap_mem     = ev[0];
            if (!r) exp_sc = '0;
            e.c   = c;
            e.to  = to;
            e.sc  = exp_sc;
            e.tag = tag;
            exp_q.push_back(e);
            tag++;
            exp_sc = exp_sc + 16'(c.stall_pc);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        ctrl_t act;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = '{bus.stall_pc, bus.stall_if, bus.stall_sub_if, bus.stall_id, bus.stall_ex,
                    bus.stall_mem, bus.flush_if, bus.flush_id, bus.flush_ex, bus.flush_mem,
                    bus.flush_sub_mem};
            n_tests += 3;
            if (act !== e.c) begin
                n_fail++;
                $display("FAIL vec%0d ctrl: got %b want %b", e.tag, act, e.c);
            end
            if (bus.dmem_timeout !== e.to) begin
                n_fail++;
                $display("FAIL vec%0d dmem_timeout: got %b want %b", e.tag, bus.dmem_timeout, e.to);
            end
            if (bus.stall_cycles !== e.sc) begin
                n_fail++;
                $display("FAIL vec%0d stall_cycles: got %0d want %0d", e.tag, bus.stall_cycles,
                         e.sc);
            end
        end
    end

    initial begin
        bus.load_use_hz  = 1'b1;
        bus.imem_busy    = 1'b1;
        bus.branch_taken = 1'b1;
        bus.dmem_busy    = 1'b1;
        bus.trap_mem     = 1'b1;

        c0 = '0;
        lu = '0; lu.stall_pc = 1; lu.stall_if = 1; lu.stall_sub_if = 1; lu.stall_id = 1;
        lu.flush_ex = 1;
        im = '0; im.stall_pc = 1; im.stall_if = 1; im.stall_sub_if = 1; im.flush_id = 1;
        br = '0; br.flush_if = 1; br.flush_id = 1;
        rd = '0; rd.flush_if = 1;
        st = '1; st.flush_if = 0; st.flush_id = 0; st.flush_ex = 0; st.flush_mem = 0;
        fl = '0; fl.flush_if = 1; fl.flush_id = 1; fl.flush_ex = 1; fl.flush_mem = 1;
        fl.flush_sub_mem = 1;

        // Reset held with every event high, then release with events idle.
        drive(2, 1'b0, 5'b11111, c0, 1'b0);
        drive(2, 1'b1, EvNone, c0, 1'b0);
        // Single-cycle load-use, then imem wait.
        drive(1, 1'b1, EvLu, lu, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        drive(1, 1'b1, EvIm, im, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        // Branch outranks load-use; redirect holds flush_if for two cycles.
        drive(1, 1'b1, EvBr | EvLu, br, 1'b0);
        drive(1, 1'b1, EvNone, rd, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        // Twenty busy cycles: timeout on the 16th, then the trap redirect is suspended.
        drive(15, 1'b1, EvDb, st, 1'b0);
        drive(1, 1'b1, EvDb, fl, 1'b1);
        drive(4, 1'b1, EvDb, st, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        drive(1, 1'b1, EvNone, rd, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        // Branch, then a 3-cycle wait suspends the remaining redirect cycle.
        drive(1, 1'b1, EvBr, br, 1'b0);
        drive(3, 1'b1, EvDb, st, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        drive(1, 1'b1, EvNone, rd, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        // Trap mid-wait clears wait_cnt: 15 more busy cycles stay short of a timeout.
        drive(5, 1'b1, EvDb, st, 1'b0);
        drive(1, 1'b1, EvDb | EvTr, fl, 1'b0);
        drive(15, 1'b1, EvDb, st, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        drive(1, 1'b1, EvNone, rd, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        // Busy outranks branch, so no redirect follows.
        drive(1, 1'b1, EvDb | EvBr, st, 1'b0);
        drive(2, 1'b1, EvNone, c0, 1'b0);
        // Trap alone, and redirect outranking imem_busy.
        drive(1, 1'b1, EvTr, fl, 1'b0);
        drive(1, 1'b1, EvNone, rd, 1'b0);
        drive(1, 1'b1, EvBr, br, 1'b0);
        drive(1, 1'b1, EvIm, rd, 1'b0);
        drive(1, 1'b1, EvIm, im, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);
        // Reset mid-redirect abandons it and clears the counter.
        drive(1, 1'b1, EvBr, br, 1'b0);
        drive(1, 1'b0, EvNone, c0, 1'b0);
        drive(2, 1'b1, EvNone, c0, 1'b0);
        drive(1, 1'b1, EvLu, lu, 1'b0);
        drive(1, 1'b1, EvNone, c0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 8-bit mimic pipeline (PC, IF, sub-IF, ID, EX, MEM, sub-MEM, register file). It turns hazard and memory-status events into the pipeline's `stall_*` and `flush_*` controls each cycle. It resolves competing events by fixed priority and holds multi-cycle redirect and data-memory-wait sequences. It also counts stalled cycles for the verification scoreboard.

## Interface
Parameters:
- `REDIRECT_CYCLES`, default 2: cycles `flush_if` stays asserted after a redirect (including the first cycle); legal range 1–15.
- `DMEM_TIMEOUT`, default 16: consecutive `dmem_busy` cycles that cause a timeout; legal range 2–255.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: the single clock.
  - `rst`, in, 1: asynchronous, active-low reset.
- Event inputs:
  - `load_use_hz`, in, 1: ID consumes the destination of a load currently in EX.
  - `imem_busy`, in, 1: instruction memory has not returned data this cycle.
  - `branch_taken`, in, 1: branch or jump resolved taken in EX.
  - `dmem_busy`, in, 1: data memory access in MEM has not completed.
  - `trap_mem`, in, 1: exception detected in MEM.
- Pipeline controls:
  - `stall_pc`, `stall_if`, `stall_sub_if`, `stall_id`, `stall_ex`, `stall_mem`, out, 1 each: hold the corresponding register.
  - `flush_if`, `flush_id`, `flush_ex`, `flush_mem`, `flush_sub_mem`, out, 1 each: load a bubble into the corresponding register.
- Status outputs:
  - `dmem_timeout`, out, 1: one-cycle pulse when a data-memory wait times out.
  - `stall_cycles`, out, `CNT_W`: saturating count of cycles with `stall_pc`=1.

## Operation
- FSM states are RUN, DMEM_WAIT and REDIRECT. Two internal counters support it:
  - `redir_cnt`, 4 bits.
  - `wait_cnt`, 8 bits.
- Controls are Mealy outputs, decoded from the current state and the inputs in the same cycle. Only the first matching line applies:
  1. `trap_mem`, or a timeout (below): assert every `flush_*`, no stalls. Next state is REDIRECT with `redir_cnt`=`REDIRECT_CYCLES`-1. Clear `wait_cnt`.
  2. `dmem_busy`: assert every `stall_*` and `flush_sub_mem`. Next state is DMEM_WAIT and `wait_cnt` increments. An active REDIRECT is suspended: `redir_cnt` is frozen and resumes afterwards.
  3. `branch_taken`: assert `flush_if` and `flush_id`. Next state is REDIRECT with `redir_cnt`=`REDIRECT_CYCLES`-1.
  4. State REDIRECT with `redir_cnt`>0: assert `flush_if`, decrement `redir_cnt`. When it reaches 0, return to RUN.
  5. `imem_busy`: assert `stall_pc`, `stall_if`, `stall_sub_if` and `flush_id`.
  6. `load_use_hz`: assert `stall_pc`, `stall_if`, `stall_sub_if`, `stall_id` and `flush_ex`.
  7. Otherwise all controls are 0.
- Timeout: a timeout fires when `dmem_busy`=1 and `wait_cnt`=`DMEM_TIMEOUT`-1. On that cycle:
  - `dmem_timeout` pulses.
  - Rule 1 applies.
- `dmem_busy` falling: DMEM_WAIT leaves with `wait_cnt` cleared. It goes to REDIRECT if a redirect was suspended, otherwise to RUN.
- `stall_cycles` increments on every cycle with `stall_pc`=1 and saturates at all-ones.
- A stall and a flush are never both asserted for the same register, except that `flush_sub_mem` is asserted with all stalls.

## Timing
- Reset (`rst`=0), asynchronous:
  - state goes to RUN;
  - `redir_cnt`, `wait_cnt` and `stall_cycles` go to 0;
  - all control outputs and `dmem_timeout` are 0 while reset is held.
- Reset asserted mid-sequence abandons any REDIRECT or DMEM_WAIT immediately.
- Event-to-control latency is 0 cycles, purely combinational from the inputs.
- A redirect holds `flush_if` for exactly `REDIRECT_CYCLES` cycles, not counting suspended cycles.
- The timeout pulse occurs on the `DMEM_TIMEOUT`-th consecutive busy cycle.
- `stall_cycles` updates on the clock edge after the stalled cycle.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - the state enum (RUN, DMEM_WAIT, REDIRECT);
  - the default parameter constants;
  - a packed struct bundling the six stalls and five flushes.
- Sub-module `sat_counter` (parameterised width, increment enable, async active-low clear) implements `stall_cycles`.

## Test plan
- Reset with all inputs 1, then release with all inputs 0 → all outputs 0, `stall_cycles`=0.
- `load_use_hz`=1 for 1 cycle → `stall_pc`/`stall_if`/`stall_sub_if`/`stall_id`=1 and `flush_ex`=1 for that cycle only; `stall_cycles`=1.
- `branch_taken` and `load_use_hz` pulsed together for 1 cycle, `REDIRECT_CYCLES`=2 → cycle 0 has `flush_if`=`flush_id`=1 with no stalls; cycle 1 has `flush_if`=1 only; cycle 2 has all 0.
- `dmem_busy` held for 20 cycles with `DMEM_TIMEOUT`=16:
  - cycles 0–14: all stalls plus `flush_sub_mem`;
  - cycle 15: `dmem_timeout`=1 with all flushes;
  - cycles 16–19: stall again, with `wait_cnt` restarting from 0.
- Branch, then `dmem_busy` for 3 cycles during the redirect → `flush_if` resumes for the remaining 1 cycle after busy drops.
- `trap_mem` during DMEM_WAIT → all flushes on that cycle, `wait_cnt` returns to 0, and no timeout pulse.
